// File: rtl/dispense_sequencer_pkg.sv
// Shared state encodings and helpers for the dispense sequencer.
package dispense_pkg;

  localparam logic [2:0] EST_LECTURA = 3'd0;
  localparam logic [2:0] EST_ESPERA  = 3'd1;
  localparam logic [2:0] EST_CARGA   = 3'd2;
  localparam logic [2:0] EST_FIN     = 3'd3;
  localparam logic [2:0] EST_ERROR   = 3'd4;

  typedef enum logic [2:0] {
    LECTURA = EST_LECTURA,
    ESPERA  = EST_ESPERA,
    CARGA   = EST_CARGA,
    FIN     = EST_FIN,
    ERROR   = EST_ERROR
  } est_t;

  // Position of the most significant set bit; 0 when the vector is empty.
  function automatic logic [4:0] hi_bit(input logic [31:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/dispense_sequencer_if.sv
// Front-end / motor-side signal bundle of the dispense sequencer.
interface dispense_sequencer_if #(
  parameter int N_CH = 3
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic            RGB_full;
  logic            enter;
  logic            abort;
  logic [N_CH-1:0] ch_mask;
  logic [N_CH-1:0] flags;
  logic [N_CH-1:0] Motores;
  logic            trigger;
  logic            busy;
  logic            done;
  logic            error;
  logic [CH_W-1:0] ch_idx;
  logic [2:0]      est;

  modport master (
    output RGB_full, enter, abort, ch_mask, flags,
    input  Motores, trigger, busy, done, error, ch_idx, est
  );

  modport slave (
    input  RGB_full, enter, abort, ch_mask, flags,
    output Motores, trigger, busy, done, error, ch_idx, est
  );
endinterface

// File: rtl/dispense_sequencer_prio_enc_hi.sv
// Highest-set-bit encoder: o_idx is the MSB position of i_vec, o_valid when any bit is set.
module prio_enc_hi
  import dispense_pkg::*;
#(
  parameter int N = 3,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  logic [31:0] w_ext;

  always_comb begin
    w_ext        = '0;
    w_ext[N-1:0] = i_vec;
  end

  assign o_idx   = W'(hi_bit(w_ext));
  assign o_valid = |i_vec;

endmodule

// File: rtl/dispense_sequencer.sv
// N-channel dispensing sequencer, highest channel first.
// Define DISPENSE_TIMEOUT_EN to build the per-channel watchdog and the ERROR state.
module dispense_sequencer
  import dispense_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input logic           clk,
  input logic           reset,
  dispense_sequencer_if.slave io
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << TIMEOUT_W)) begin : g_badTimeout
    $error("TIMEOUT_CYC must lie in [1, 2**TIMEOUT_W)");
  end

  est_t            r_est;
  logic [N_CH-1:0] r_pend;
  logic [CH_W-1:0] r_chIdx;
  logic [N_CH-1:0] r_motores;
  logic            r_trigger;
  logic            r_busy;
  logic            r_done;
`ifdef DISPENSE_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_wdog;
  logic                 r_error;
`endif

  logic [N_CH-1:0] w_curHot;
  logic [N_CH-1:0] w_pendNext;
  logic            w_flagHit;
  logic [N_CH-1:0] w_encIn;
  logic [CH_W-1:0] w_encIdx;
  logic            w_encValid;

  assign w_curHot   = N_CH'(1) << r_chIdx;
  assign w_pendNext = r_pend & ~w_curHot;
  assign w_flagHit  = |(io.flags & w_curHot);

  // One encoder serves both the start (raw mask) and each advance (remaining channels).
  assign w_encIn = (r_est == CARGA) ? w_pendNext : io.ch_mask;

  prio_enc_hi #(.N(N_CH), .W(CH_W)) u_prioEnc (
    .i_vec   (w_encIn),
    .o_idx   (w_encIdx),
    .o_valid (w_encValid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_est     <= LECTURA;
      r_pend    <= '0;
      r_chIdx   <= '0;
      r_motores <= '0;
      r_trigger <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef DISPENSE_TIMEOUT_EN
      r_wdog    <= '0;
      r_error   <= 1'b0;
`endif
    end else begin
      r_trigger <= 1'b0;
      r_done    <= 1'b0;
      if (io.abort) begin
        r_est     <= LECTURA;
        r_pend    <= '0;
        r_chIdx   <= '0;
        r_motores <= '0;
        r_busy    <= 1'b0;
`ifdef DISPENSE_TIMEOUT_EN
        r_wdog    <= '0;
        r_error   <= 1'b0;
`endif
      end else begin
        case (r_est)
          LECTURA: if (io.RGB_full) r_est <= ESPERA;
          ESPERA: begin
            if (!io.RGB_full) begin
              r_est <= LECTURA;
            end else if (io.enter) begin
              r_pend <= io.ch_mask;
              if (!w_encValid) begin
                r_est  <= FIN;
                r_done <= 1'b1;
              end else begin
                r_est     <= CARGA;
                r_chIdx   <= w_encIdx;
                r_motores <= N_CH'(1) << w_encIdx;
                r_trigger <= 1'b1;
                r_busy    <= 1'b1;
`ifdef DISPENSE_TIMEOUT_EN
                r_wdog    <= '0;
`endif
              end
            end
          end
          CARGA: begin
            // A completion flag outranks a watchdog expiry landing on the same edge.
            if (w_flagHit) begin
              r_pend <= w_pendNext;
`ifdef DISPENSE_TIMEOUT_EN
              r_wdog <= '0;
`endif
              if (!w_encValid) begin
                r_est     <= FIN;
                r_motores <= '0;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
              end else begin
                r_chIdx   <= w_encIdx;
                r_motores <= N_CH'(1) << w_encIdx;
                r_trigger <= 1'b1;
              end
            end
`ifdef DISPENSE_TIMEOUT_EN
            else if (r_wdog == TIMEOUT_W'(TIMEOUT_CYC - 1)) begin
              r_est     <= ERROR;
              r_motores <= '0;
              r_busy    <= 1'b0;
              r_error   <= 1'b1;
              r_wdog    <= '0;
            end else begin
              r_wdog <= r_wdog + 1'b1;
            end
`endif
          end
          FIN: r_est <= LECTURA;
`ifdef DISPENSE_TIMEOUT_EN
          ERROR: begin
            if (io.enter) begin
              r_est   <= LECTURA;
              r_error <= 1'b0;
              r_pend  <= '0;
            end
          end
`endif
          default: begin
            r_est     <= LECTURA;
            r_motores <= '0;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io.Motores = r_motores;
  assign io.trigger = r_trigger;
  assign io.busy    = r_busy;
  assign io.done    = r_done;
  assign io.ch_idx  = r_chIdx;
  assign io.est     = r_est;
`ifdef DISPENSE_TIMEOUT_EN
  assign io.error   = r_error;
`else
  assign io.error   = 1'b0;
`endif

endmodule

// File: doc/dispense_sequencer.md
# dispense_sequencer

Parametrised N-channel dispensing sequencer: after a colour reading is complete and the operator presses enter, it drives one motor at a time, highest channel first, advancing on each channel's completion flag. It adds per-sequence channel masking (skipping unused colours), abort, a per-channel timeout watchdog with an error state, and busy/done status. It sits between the colour-reading/keypad front end and the motor drivers, and exports its state for the display.

## Interface
- `N_CH`, 3: number of dispensing channels/motors (≥1).
- `TIMEOUT_W`, 16: width of the watchdog counter.
- `TIMEOUT_CYC`, 50000: cycles allowed per channel before error. Must satisfy 1 ≤ `TIMEOUT_CYC` < 2^`TIMEOUT_W`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `RGB_full` in 1: the colour reading is complete and valid.
- `enter` in 1: start request; level sampled each cycle.
- `abort` in 1: cancel any operation.
- `ch_mask` in N_CH: channels to dispense, latched on start.
- `flags` in N_CH: per-channel "load complete".
- `Motores` out N_CH: one-hot motor enable, bit N_CH-1 first.
- `trigger` out 1: one-cycle pulse on the first cycle of each channel load.
- `busy` out 1: high in CARGA.
- `done` out 1: one-cycle pulse on sequence completion.
- `error` out 1: high in ERROR.
- `ch_idx` out max(1,$clog2(N_CH)): active channel, or the failed channel while in ERROR.
- `est` out 3: current state encoding.

## Operation
- States and encodings: LECTURA=0, ESPERA=1, CARGA=2, FIN=3, ERROR=4. Any other value goes to LECTURA.
- LECTURA: go to ESPERA if `RGB_full`.
- ESPERA:
  - If `!RGB_full`, go to LECTURA.
  - Else if `enter`, latch `ch_mask` into `pend`.
    - If `pend`==0, go to FIN.
    - Otherwise load `ch_idx` with the highest set bit of `pend` and go to CARGA.
- CARGA: `Motores`=onehot(`ch_idx`).
  - On `flags[ch_idx]`, clear `pend[ch_idx]`.
    - If the remaining `pend` is empty, go to FIN.
    - Otherwise load the next-highest set bit into `ch_idx` and stay in CARGA. The watchdog clears and `trigger` pulses again.
  - `flags` of non-active channels are ignored.
  - `enter` is ignored.
- FIN: assert `done` for one cycle, then go to LECTURA.
- ERROR: all motors off. Exit to LECTURA on `enter` or `abort`.
- `abort` in any state other than LECTURA goes to LECTURA, clears `pend` and the watchdog, and produces no `done`. `abort` has the highest priority after `reset`.
- Priority within CARGA: `abort` > flag > timeout.
- Outputs are decoded from registered state only. There is no combinational path from inputs to outputs.

## Timing
- On `reset`, every output is 0: `Motores`=0, `trigger`=0, `busy`=0, `done`=0, `error`=0, `ch_idx`=0, `est`=0. `pend` and the watchdog are also cleared. `reset` mid-sequence stops the motors in the following cycle.
- `enter` sampled at edge t: in cycle t+1, `Motores` is valid and `trigger`=1.
- A flag sampled at edge t switches `Motores` to the next channel, or to 0, in cycle t+1. There is never a cycle with two motors on.
- Skipped channels cost zero cycles.
- Watchdog behaviour:
  - It counts cycles in CARGA for the current channel.
  - When the count equals `TIMEOUT_CYC`-1 and there is no flag, the block enters ERROR at the next edge.
  - Each channel therefore gets exactly `TIMEOUT_CYC` cycles of `Motores`.
  - The counter never wraps.
- `done` goes high exactly one cycle after the last flag edge, then `est` returns to 0.

## Configuration
- `DISPENSE_TIMEOUT_EN` defined: the watchdog counter and the ERROR state are present.
- `DISPENSE_TIMEOUT_EN` undefined:
  - No counter is built.
  - CARGA waits indefinitely for the flag.
  - `error` is tied to 0 and ERROR is unreachable.
  - `TIMEOUT_W` and `TIMEOUT_CYC` are unused.

## Structure
- Package `dispense_pkg` holds:
  - the state encoding constants (3-bit);
  - an `est_t` typedef;
  - a function that returns the highest set bit of a vector.
- One sub-module, `prio_enc_hi`: a parametrised N-bit highest-set-bit encoder with a valid output. It is used both at start and at each channel advance.

## Test plan
- Full sequence: N_CH=3, `ch_mask`=111, `RGB_full`=1, `enter` pulse, flags 100/010/001 at 5-cycle gaps.
  - `Motores` goes 100→010→001→000.
  - `trigger` pulses 3 times.
  - `done` is one cycle; `est` goes 2→3→0.
- Skip: `ch_mask`=101.
  - `Motores` goes 100→001; 010 is never asserted.
  - A stray `flags[1]` while channel 2 is active is ignored.
- Empty mask: `ch_mask`=000, then `enter`.
  - `est` goes 1→3→0; `done`=1 for one cycle.
  - `Motores` stays 000 and `trigger` never fires.
- Timeout (defined, `TIMEOUT_CYC`=8), no flag.
  - `Motores`=100 for exactly 8 cycles.
  - Then `est`=4, `error`=1, `ch_idx`=2, `Motores`=000.
  - `enter` then returns to `est`=0.
- Flag on the timeout cycle: `flags[2]` lands in the 8th cycle.
  - The sequence advances to channel 1 and no error occurs.
- Abort and reset:
  - `abort` during channel 1 gives `Motores`=000 and `est`=0 the next cycle, with no `done`.
  - Synchronous `reset` mid-CARGA gives all outputs 0 after the edge.
  - `!RGB_full` in ESPERA returns to LECTURA.
